btn_conditioner: RTL and testbench
==================================

# btn_conditioner

Input-conditioning block that sits directly upstream of the CPU's `btn[3:0]` input. It takes raw, asynchronous, bouncing push-button pins and synchronises and debounces each one independently. It presents three views to the CPU's memory-mapped I/O: a stable level, a one-cycle press pulse, and a sticky press flag that software clears. A per-button wrap-around press counter is also provided for diagnostics.

## Interface
Parameters:
- `N_BTN`, 4, number of independent button channels.
- `DEBOUNCE_CYCLES`, 1_000_000, consecutive stable cycles required before a level change is accepted (10 ms at 100 MHz); legal range 2 to 2^24.
- `CNT_W`, $clog2(DEBOUNCE_CYCLES), width of the debounce counter (derived; do not override).

Ports:
- `clk`  in  1  system clock; same clock as the CPU.
- `reset`  in  1  asynchronous, active-low reset.
- `btn_raw`  in  N_BTN  raw button pins, active-high, asynchronous to `clk`.
- `sticky_clr`  in  N_BTN  per-bit clear of `btn_sticky`, one-cycle MMIO write strobe.
- `btn_level`  out  N_BTN  debounced level; drives CPU `btn`.
- `btn_press`  out  N_BTN  one-cycle pulse on each accepted press (rising edge of `btn_level`).
- `btn_sticky`  out  N_BTN  set on press and held until cleared.
- `press_count`  out  8*N_BTN  per-channel 8-bit press counter, channel i at bits [8i+7:8i].

## Operation
- Synchroniser: two flops per channel; the output `sync[i]` is the only signal used downstream.
- Per-channel FSM with four states:
  - RELEASED: `level`=0. `sync`=1 → PRESSING, counter=0.
  - PRESSING: `sync`=0 → RELEASED. Counter reaches DEBOUNCE_CYCLES-1 with `sync`=1 → PRESSED, `level`←1, `press` pulses.
  - PRESSED: `level`=1. `sync`=0 → RELEASING, counter=0.
  - RELEASING: `sync`=1 → PRESSED, no pulse. Counter reaches DEBOUNCE_CYCLES-1 with `sync`=0 → RELEASED, `level`←0.
- Counter increments only in PRESSING/RELEASING and holds at 0 otherwise; it never exceeds DEBOUNCE_CYCLES-1.
- Sticky flag:
  - `btn_press[i]` sets `btn_sticky[i]`; `sticky_clr[i]` clears it.
  - If both occur in the same cycle, the set wins.
- `press_count[i]` increments on each `btn_press[i]`, modulo 256 (255→0); there is no clear other than reset.
- Channels are fully independent; simultaneous events on different channels have no interaction.

## Timing
- Reset (async assert, sync release): all sync flops 0, all FSMs RELEASED, counters 0, `btn_level`=0, `btn_press`=0, `btn_sticky`=0, `press_count`=0.
- A glitch on `btn_raw` during reset is ignored. Reset asserted mid-debounce abandons the pending transition with no pulse.
- Latency, `btn_raw` rise (held clean) to `btn_level` rise: 2 sync cycles + DEBOUNCE_CYCLES cycles. `btn_press` is high in the same cycle `btn_level` first reads 1. Release latency is identical.
- Bounce: any return of `sync` to the accepted level before the count completes aborts the transition; a new full DEBOUNCE_CYCLES window starts on the next change.
- `btn_sticky` rises one cycle after `btn_press`. `sticky_clr` takes effect on the next edge.
- `press_count` updates one cycle after `btn_press`.
- All outputs are registered.

## Structure
- Package `cpu_io_pkg` holds:
  - the `btn_state_t` enum (RELEASED, PRESSING, PRESSED, RELEASING);
  - the default `DEBOUNCE_CYCLES` constant;
  - the press-counter width constant (8).
- Sub-module `btn_debounce_ch`: one channel containing the synchroniser, FSM, counter, sticky flag and press counter. `btn_conditioner` generates N_BTN instances and packs their outputs.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 unless noted.
- Clean press: `btn_raw[0]` 0→1 held 10 cycles → `btn_level[0]`=1 exactly 6 cycles after the edge, `btn_press[0]` high 1 cycle, `btn_sticky[0]`=1, `press_count[0]`=1; other channels stay 0.
- Bounce reject: `btn_raw[1]` toggles 1,0,1,0 every 2 cycles, then held at 0 → `btn_level[1]` never rises, no press pulse, `press_count[1]`=0.
- Sticky collision: hold `btn_sticky[2]`=1, then assert `sticky_clr[2]` in the same cycle as a new `btn_press[2]` → `btn_sticky[2]` stays 1. A later `sticky_clr[2]` alone → 0.
- Counter wrap: 256 clean presses on channel 3 → `press_count[3]` goes 255→0; `btn_sticky[3]` still 1.
- Reset mid-debounce: assert `reset`=0 while channel 0 is in PRESSING (2 of 4 cycles counted) → all outputs 0 immediately. Release reset with the pin still high → full 6-cycle latency restarts, then exactly one press pulse.
- Simultaneous: all four pins rise on the same cycle → all four `btn_press` bits pulse on the same cycle, `press_count` = 1 on every channel.

Source files
------------

// File: rtl/cpu_io_pkg.sv
// Shared types and constants for the CPU push-button input path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_io_pkg;

    // Debounce FSM state for one button channel
    typedef enum logic [1:0] {
        RELEASED,
        PRESSING,
        PRESSED,
        RELEASING
    } btn_state_t;

    // 10 ms of stability at a 100 MHz core clock
    localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

    // Width of each per-channel diagnostic press counter
    localparam int PRESS_CNT_W = 8;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce FSM, sticky flag, press counter.
// Latency: raw edge to level/press = 2 + DEBOUNCE_CYCLES cycles; sticky/count one cycle later.
// Backpressure: none; every accepted press is reported unconditionally.
module btn_debounce_ch
    import cpu_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   raw,
    input  logic                   clr,
    output logic                   level,
    output logic                   press,
    output logic                   sticky,
    output logic [PRESS_CNT_W-1:0] count
);

    // The cycle that enters PRESSING/RELEASING counts as the first stable
    // cycle, so the transition fires when the counter sits at D-2; the
    // counter therefore never exceeds D-1 and the latency is exactly D.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

    logic             meta;
    logic             sync;
    btn_state_t       state;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchroniser; only sync is used downstream
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= raw;
            sync <= meta;
        end
    end

    // Debounce FSM with registered level and one-cycle press pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RELEASED;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            case (state)
                RELEASED: begin
                    cnt <= '0;
                    if (sync) state <= PRESSING;
                end
                PRESSING: begin
                    if (!sync) begin
                        state <= RELEASED;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= PRESSED;
                        cnt   <= '0;
                        level <= 1'b1;
                        press <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    cnt <= '0;
                    if (!sync) state <= RELEASING;
                end
                RELEASING: begin
                    if (sync) begin
                        // bounce back to pressed: no new pulse
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= RELEASED;
                        cnt   <= '0;
                        level <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= RELEASED;
                    cnt   <= '0;
                    level <= 1'b0;
                end
            endcase
        end
    end

    // Sticky flag (set beats clear) and wrap-around press counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sticky <= 1'b0;
            count  <= '0;
        end else begin
            if (press)
                sticky <= 1'b1;
            else if (clr)
                sticky <= 1'b0;
            if (press)
                count <= count + PRESS_CNT_W'(1);
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// Conditions N_BTN raw push-button pins into level, press pulse, sticky flag and press count.
// Latency: 2 + DEBOUNCE_CYCLES cycles from a clean pin edge to btn_level/btn_press.
// Backpressure: none; channels are independent and free-running.
module btn_conditioner
    import cpu_io_pkg::*;
#(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_BTN-1:0]             btn_raw,
    input  logic [N_BTN-1:0]             sticky_clr,
    output logic [N_BTN-1:0]             btn_level,
    output logic [N_BTN-1:0]             btn_press,
    output logic [N_BTN-1:0]             btn_sticky,
    output logic [PRESS_CNT_W*N_BTN-1:0] press_count
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .raw    (btn_raw[i]),
            .clr    (sticky_clr[i]),
            .level  (btn_level[i]),
            .press  (btn_press[i]),
            .sticky (btn_sticky[i]),
            .count  (press_count[PRESS_CNT_W*i +: PRESS_CNT_W])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEBOUNCE_CYCLES=4.
// Table-driven per-cycle vectors plus hand-written multi-cycle sequences.
// Outputs are sampled 1 time unit after each rising clock edge.
module tb_btn_conditioner;

    logic        clk;
    logic        reset;
    logic [3:0]  btn_raw;
    logic [3:0]  sticky_clr;
    logic [3:0]  btn_level;
    logic [3:0]  btn_press;
    logic [3:0]  btn_sticky;
    logic [31:0] press_count;

    int n_total;
    int n_pass;

    typedef struct packed {
        logic [3:0]  raw;
        logic [3:0]  clr;
        logic [3:0]  level;
        logic [3:0]  press;
        logic [3:0]  sticky;
        logic [31:0] count;
    } vec_t;

    vec_t vecs [24];

    btn_conditioner #(
        .N_BTN           (4),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .sticky_clr  (sticky_clr),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_sticky  (btn_sticky),
        .press_count (press_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // advance n rising edges and land 1 unit after the last one
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int idx, input logic [3:0] raw, input logic [3:0] clr,
                           input logic [3:0] level, input logic [3:0] press,
                           input logic [3:0] sticky, input logic [31:0] count);
        vecs[idx].raw    = raw;
        vecs[idx].clr    = clr;
        vecs[idx].level  = level;
        vecs[idx].press  = press;
        vecs[idx].sticky = sticky;
        vecs[idx].count  = count;
    endtask

    task automatic apply_vecs(input int lo, input int hi);
        cycles(1);
        for (int i = lo; i <= hi; i++) begin
            btn_raw    = vecs[i].raw;
            sticky_clr = vecs[i].clr;
            cycles(1);
            check($sformatf("vec%0d level", i),  {28'd0, btn_level},  {28'd0, vecs[i].level});
            check($sformatf("vec%0d press", i),  {28'd0, btn_press},  {28'd0, vecs[i].press});
            check($sformatf("vec%0d sticky", i), {28'd0, btn_sticky}, {28'd0, vecs[i].sticky});
            check($sformatf("vec%0d count", i),  press_count,         vecs[i].count);
        end
    endtask

    // bounded wait for a press pulse on one channel; returns in the pulse cycle
    task automatic wait_press(input int ch, input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            cycles(1);
            if (btn_press[ch]) seen = 1'b1;
        end
        check(name, {31'd0, seen}, 32'd1);
    endtask

    initial begin
        int  n_press;
        bit  saw;

        n_total    = 0;
        n_pass     = 0;
        reset      = 1'b0;
        btn_raw    = 4'h0;
        sticky_clr = 4'h0;

        // clean press on ch0, release, then clear sticky
        for (int i = 0; i <= 4; i++)   set_vec(i, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 32'h0);
        set_vec(5, 4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 32'h0);
        for (int i = 6; i <= 9; i++)   set_vec(i, 4'h1, 4'h0, 4'h1, 4'h0, 4'h1, 32'h1);
        for (int i = 10; i <= 14; i++) set_vec(i, 4'h0, 4'h0, 4'h1, 4'h0, 4'h1, 32'h1);
        set_vec(15, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 32'h1);
        set_vec(16, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 32'h1);
        // all four pins rise together (run from reset)
        for (int i = 17; i <= 21; i++) set_vec(i, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 32'h0);
        set_vec(22, 4'hF, 4'h0, 4'hF, 4'hF, 4'h0, 32'h0);
        set_vec(23, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 32'h01010101);

        // reset state, with a pin glitch while reset is held
        #2  btn_raw = 4'b0101;
        #10 btn_raw = 4'h0;
        #10;
        check("rst level",  {28'd0, btn_level},  32'h0);
        check("rst press",  {28'd0, btn_press},  32'h0);
        check("rst sticky", {28'd0, btn_sticky}, 32'h0);
        check("rst count",  press_count,         32'h0);
        @(negedge clk) reset = 1'b1;
        saw = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cycles(1);
            if (btn_level != 4'h0 || btn_press != 4'h0) saw = 1'b1;
        end
        check("glitch in reset ignored", {31'd0, saw}, 32'h0);

        apply_vecs(0, 16);

        // bounce on ch1: 1,0,1,0 every 2 cycles, then held low
        saw = 1'b0;
        for (int k = 0; k < 4; k++) begin
            btn_raw[1] = ~k[0];
            for (int c = 0; c < 2; c++) begin
                cycles(1);
                if (btn_level[1] || btn_press[1]) saw = 1'b1;
            end
        end
        btn_raw[1] = 1'b0;
        for (int c = 0; c < 12; c++) begin
            cycles(1);
            if (btn_level[1] || btn_press[1]) saw = 1'b1;
        end
        check("bounce no level/press", {31'd0, saw}, 32'h0);
        check("bounce count ch1", {24'd0, press_count[15:8]}, 32'h0);

        // sticky collision on ch2: clear in the same cycle as a new press
        btn_raw[2] = 1'b1;
        wait_press(2, "ch2 first press");
        cycles(3);
        check("ch2 sticky after press", {31'd0, btn_sticky[2]}, 32'h1);
        btn_raw[2] = 1'b0;
        cycles(8);
        btn_raw[2] = 1'b1;
        wait_press(2, "ch2 second press");
        sticky_clr[2] = 1'b1;
        cycles(1);
        sticky_clr[2] = 1'b0;
        check("ch2 set beats clear", {31'd0, btn_sticky[2]}, 32'h1);
        check("ch2 count", {24'd0, press_count[23:16]}, 32'd2);
        btn_raw[2] = 1'b0;
        cycles(8);
        sticky_clr[2] = 1'b1;
        cycles(1);
        sticky_clr[2] = 1'b0;
        check("ch2 clear alone", {31'd0, btn_sticky[2]}, 32'h0);

        // 256 presses on ch3: counter wraps 255 -> 0
        for (int p = 1; p <= 256; p++) begin
            btn_raw[3] = 1'b1;
            cycles(8);
            btn_raw[3] = 1'b0;
            cycles(8);
            if (p == 1)   check("ch3 count 1",   {24'd0, press_count[31:24]}, 32'd1);
            if (p == 255) check("ch3 count 255", {24'd0, press_count[31:24]}, 32'd255);
        end
        check("ch3 count wrap", {24'd0, press_count[31:24]}, 32'd0);
        check("ch3 sticky after wrap", {31'd0, btn_sticky[3]}, 32'h1);

        // reset while ch0 is two counts into PRESSING
        btn_raw[0] = 1'b1;
        cycles(5);
        reset = 1'b0;
        #1;
        check("midrst level",  {28'd0, btn_level},  32'h0);
        check("midrst press",  {28'd0, btn_press},  32'h0);
        check("midrst sticky", {28'd0, btn_sticky}, 32'h0);
        check("midrst count",  press_count,         32'h0);
        @(negedge clk) reset = 1'b1;
        cycles(5);
        check("midrst level before latency", {31'd0, btn_level[0]}, 32'h0);
        cycles(1);
        check("midrst level at latency", {31'd0, btn_level[0]}, 32'h1);
        n_press = btn_press[0] ? 1 : 0;
        for (int k = 0; k < 12; k++) begin
            cycles(1);
            if (btn_press[0]) n_press++;
        end
        check("midrst single pulse", n_press, 32'd1);
        check("midrst count ch0", {24'd0, press_count[7:0]}, 32'd1);

        // fresh reset, then all channels at once
        btn_raw = 4'h0;
        reset   = 1'b0;
        #3;
        @(negedge clk) reset = 1'b1;
        apply_vecs(17, 23);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
